// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: PC register, instruction-memory address and the IF/ID latch, with stall and redirect handling.
// Optional FETCH_PERF_CNT_EN adds saturating stall_cnt/redirect_cnt outputs.
module instruction_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch,
  input  logic        branch_eq,
  input  logic [1:0]  jump,
  input  logic [31:0] jr_addr,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] redirect_cnt
`endif
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        take_br, take_jal, take_jr, redirect;
  logic [31:0] pc_plus4, br_tgt, jal_tgt, jr_tgt, redirect_tgt;

  always_comb begin
    pc_plus4 = pc_q + 32'd4;
    br_tgt   = pc4_q + {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
    jal_tgt  = {pc4_q[31:28], inst_q[25:0], 2'b00};
    jr_tgt   = jr_addr & ~32'h3;

    // A bubble in IF/ID carries no decision, so it must never redirect.
    take_jal = valid_q & (jump == 2'b10);
    take_jr  = valid_q & (jump == 2'b01);
    take_br  = valid_q & branch & branch_eq;
    redirect = take_jal | take_jr | take_br;

    if (take_jal)     redirect_tgt = jal_tgt;
    else if (take_jr) redirect_tgt = jr_tgt;
    else              redirect_tgt = br_tgt;

    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;

    if (!stall) begin
      if (redirect) begin
        pc_d    = redirect_tgt;
        inst_d  = NOP_INST;
        pc4_d   = '0;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_plus4;
        inst_d  = imem_rdata;
        pc4_d   = pc_plus4;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= PC_RESET;
      inst_q  <= NOP_INST;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    redirect_cnt_d = redirect_cnt_q;
    if (stall && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (!stall && redirect && (redirect_cnt_q != '1))
      redirect_cnt_d = redirect_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign stall_cnt    = stall_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Scoreboard bench for instruction_fetch_stage: a behavioural fetch model pushes expected state per edge,
// a monitor pops and compares after each rising edge. Directed cases, then randomized ID decisions.
module tb_instruction_fetch_stage;

  localparam logic [31:0] PCR = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall, branch, branch_eq;
  logic [1:0]  jump;
  logic [31:0] jr_addr;
  logic [31:0] if_id_inst, if_id_pc4;
  logic        if_id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt, redirect_cnt;
`endif

  instruction_fetch_stage #(.PC_RESET(PCR), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall), .branch(branch), .branch_eq(branch_eq), .jump(jump), .jr_addr(jr_addr),
    .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, inst, pc4;
    logic        valid;
    logic [31:0] scnt, rcnt;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;

  logic [31:0] m_pc, m_inst, m_pc4, m_scnt, m_rcnt;
  logic        m_valid;
  logic [31:0] ov[logic [31:0]];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ov.exists(a)) return ov[a];
    return a * 32'h9E37_79B9 + 32'h1234_5677;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = PCR; m_inst = NOP; m_pc4 = '0; m_valid = 1'b0; m_scnt = '0; m_rcnt = '0;
  endfunction

  // Applies the inputs currently driven to the model and queues the state expected after the next edge.
  function automatic void model_push();
    logic        red;
    logic [31:0] tgt;
    int          off;
    if (stall) begin
      if (m_scnt != '1) m_scnt = m_scnt + 1;
    end else begin
      red = m_valid && (jump == 2'b10 || jump == 2'b01 || (branch && branch_eq));
      if (red) begin
        off = int'($signed(m_inst[15:0])) * 4;
        if (jump == 2'b10)      tgt = {m_pc4[31:28], m_inst[25:0], 2'b00};
        else if (jump == 2'b01) tgt = {jr_addr[31:2], 2'b00};
        else                    tgt = m_pc4 + 32'(off);
        m_pc = tgt; m_inst = NOP; m_pc4 = '0; m_valid = 1'b0;
        if (m_rcnt != '1) m_rcnt = m_rcnt + 1;
      end else begin
        m_inst = mem_word(m_pc); m_pc4 = m_pc + 4; m_valid = 1'b1; m_pc = m_pc + 4;
      end
    end
    exp_q.push_back('{m_pc, m_inst, m_pc4, m_valid, m_scnt, m_rcnt});
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("imem_addr", imem_addr, e.pc);
        check("if_id_inst", if_id_inst, e.inst);
        check("if_id_pc4", if_id_pc4, e.pc4);
        check("if_id_valid", 32'(if_id_valid), 32'(e.valid));
`ifdef FETCH_PERF_CNT_EN
        check("stall_cnt", stall_cnt, e.scnt);
        check("redirect_cnt", redirect_cnt, e.rcnt);
`endif
      end
    end
  end

  task automatic step(input logic s, input logic b, input logic be, input logic [1:0] j, input logic [31:0] ja);
    @(negedge clk);
    stall = s; branch = b; branch_eq = be; jump = j; jr_addr = ja;
    model_push();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 2'b00, 32'h0);
  endtask

  // Puts word at addr into IF/ID (pc4 = addr+4) by a jr redirect followed by one fetch.
  task automatic place(input logic [31:0] addr, input logic [31:0] word);
    ov[addr] = word;
    if (!m_valid) idle();
    step(1'b0, 1'b0, 1'b0, 2'b01, addr);
    idle();
  endtask

  task automatic reset_pulse_in_stall();
    @(negedge clk);
    stall = 1'b1; branch = 1'b0; branch_eq = 1'b0; jump = 2'b01; jr_addr = 32'h0000_0700;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_pc", imem_addr, PCR);
    check("async_rst_valid", 32'(if_id_valid), 32'h0);
    check("async_rst_inst", if_id_inst, NOP);
    check("async_rst_pc4", if_id_pc4, 32'h0);
    #1 rst_n = 1'b1;
    stall = 1'b0; jump = 2'b00;
    model_reset();
    model_push();
    @(posedge clk);
    #2;
  endtask

  logic [31:0] hold_pc, hold_inst, hold_pc4;

  initial begin
    stall = 1'b0; branch = 1'b0; branch_eq = 1'b0; jump = 2'b00; jr_addr = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_pc", imem_addr, PCR);
    check("rst_inst", if_id_inst, NOP);
    check("rst_pc4", if_id_pc4, 32'h0);
    check("rst_valid", 32'(if_id_valid), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    model_push();
    @(posedge clk);
    #2;
    check("run0_pc", imem_addr, 32'h4);
    check("run0_pc4", if_id_pc4, 32'h4);
    check("run0_valid", 32'(if_id_valid), 32'h1);
    idle();
    check("run1_pc", imem_addr, 32'h8);
    check("run1_pc4", if_id_pc4, 32'h8);
    idle();
    check("run2_pc4", if_id_pc4, 32'hC);

    place(32'h0000_000C, 32'h1000_0003);
    check("beq_setup_pc4", if_id_pc4, 32'h10);
    step(1'b0, 1'b1, 1'b1, 2'b00, 32'h0);
    check("beq_taken_pc", imem_addr, 32'h1C);
    check("beq_taken_bubble", 32'(if_id_valid), 32'h0);
    idle();
    check("after_bubble_valid", 32'(if_id_valid), 32'h1);

    place(32'h0000_000C, 32'h1000_0003);
    step(1'b0, 1'b1, 1'b0, 2'b00, 32'h0);
    check("beq_nt_pc", imem_addr, 32'h14);
    check("beq_nt_valid", 32'(if_id_valid), 32'h1);

    place(32'h0000_001C, 32'h1000_FFFE);
    step(1'b0, 1'b1, 1'b1, 2'b00, 32'h0);
    check("beq_neg_pc", imem_addr, 32'h18);

    place(32'h3000_0004, 32'h0C00_0040);
    check("jal_setup_pc4", if_id_pc4, 32'h3000_0008);
    step(1'b0, 1'b0, 1'b0, 2'b10, 32'h0);
    check("jal_pc", imem_addr, 32'h3000_0100);

    idle();
    step(1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0043);
    check("jr_pc", imem_addr, 32'h0000_0040);

    idle();
    hold_pc = imem_addr; hold_inst = if_id_inst; hold_pc4 = if_id_pc4;
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0200);
      check("stall_pc", imem_addr, hold_pc);
      check("stall_inst", if_id_inst, hold_inst);
      check("stall_pc4", if_id_pc4, hold_pc4);
    end
    step(1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0200);
    check("post_stall_redirect", imem_addr, 32'h0000_0200);

    step(1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0500);
    check("bubble_no_redirect", imem_addr, 32'h0000_0204);

    place(32'hFFFF_FFF8, 32'h0000_0000);
    check("wrap_setup_pc", imem_addr, 32'hFFFF_FFFC);
    idle();
    check("wrap_pc", imem_addr, 32'h0);

    idle();
    reset_pulse_in_stall();

`ifdef FETCH_PERF_CNT_EN
    for (int unsigned i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    step(1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0080);
    idle();
    step(1'b0, 1'b0, 1'b0, 2'b01, 32'h0000_0090);
    check("perf_stall_cnt", stall_cnt, 32'd3);
    check("perf_redirect_cnt", redirect_cnt, 32'd2);

    @(negedge clk);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.stall_cnt_q;
    m_scnt = 32'hFFFF_FFFF;
    step(1'b1, 1'b0, 1'b0, 2'b00, 32'h0);
    check("perf_stall_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

    for (int unsigned i = 0; i < 400; i++) begin
      step(logic'($urandom_range(0, 4) == 0), logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 1)), 2'($urandom), $urandom);
    end

    for (int unsigned i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
